// File: rtl/permutation_sequencer_if.sv
// Bus between the AEAD mode controller and the Ascon permutation engine.
// The data_i rate word exists only when ASCON_PERM_ABSORB_EN is defined.
interface permutation_sequencer_if;
   logic             start_i;
   logic [1:0]       rounds_i;
   logic [4:0][63:0] state_i;
`ifdef ASCON_PERM_ABSORB_EN
   logic [63:0]      data_i;
`endif
   logic [4:0][63:0] state_o;
   logic [3:0]       round_o;
   logic             busy_o;
   logic             done_o;

`ifdef ASCON_PERM_ABSORB_EN
   modport slave  (input  start_i, rounds_i, state_i, data_i,
                   output state_o, round_o, busy_o, done_o);
   modport master (output start_i, rounds_i, state_i, data_i,
                   input  state_o, round_o, busy_o, done_o);
`else
   modport slave  (input  start_i, rounds_i, state_i,
                   output state_o, round_o, busy_o, done_o);
   modport master (output start_i, rounds_i, state_i,
                   input  state_o, round_o, busy_o, done_o);
`endif
endinterface

// File: rtl/permutation_sequencer.sv
// Iterative Ascon permutation engine running one round per clock (p^12, p^8, p^6).
// Optional macro ASCON_PERM_ABSORB_EN folds data_i into word 0 when a run is loaded.
module permutation_sequencer (
   input logic                    clock_i,
   input logic                    reset_i,
   permutation_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsmT;

   fsmT              fsm_q, fsm_d;
   logic [4:0][63:0] sreg_q, sreg_d;
   logic [3:0]       round_q, round_d;
   logic [4:0][63:0] loadState;
   logic [3:0]       firstRound;

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // One full round: constant addition, bitsliced S-box layer, linear diffusion.
   function automatic logic [4:0][63:0] asconRound(input logic [4:0][63:0] s,
                                                   input logic [3:0]       i);
      logic [4:0][63:0] x;
      logic [63:0]      t0, t1, t2, t3, t4;
      x = s;
      x[2][7:0] = x[2][7:0] ^ {4'd15 - i, i};
      x[0] = x[0] ^ x[4];
      x[4] = x[4] ^ x[3];
      x[2] = x[2] ^ x[1];
      t0 = ~x[0] & x[1];
      t1 = ~x[1] & x[2];
      t2 = ~x[2] & x[3];
      t3 = ~x[3] & x[4];
      t4 = ~x[4] & x[0];
      x[0] = x[0] ^ t1;
      x[1] = x[1] ^ t2;
      x[2] = x[2] ^ t3;
      x[3] = x[3] ^ t4;
      x[4] = x[4] ^ t0;
      x[1] = x[1] ^ x[0];
      x[0] = x[0] ^ x[4];
      x[3] = x[3] ^ x[2];
      x[2] = ~x[2];
      x[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
      x[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
      x[2] = x[2] ^ ror64(x[2],  1) ^ ror64(x[2],  6);
      x[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
      x[4] = x[4] ^ ror64(x[4],  7) ^ ror64(x[4], 41);
      return x;
   endfunction

   // Shorter permutations run the tail of the 12-round schedule, so they start mid-way.
   always_comb begin
      firstRound = 4'd0;
      case (bus.rounds_i)
         2'b01:   firstRound = 4'd4;
         2'b10:   firstRound = 4'd6;
         default: firstRound = 4'd0;
      endcase
   end

   always_comb begin
      loadState = bus.state_i;
`ifdef ASCON_PERM_ABSORB_EN
      loadState[0] = bus.state_i[0] ^ bus.data_i;
`endif
   end

   // DONE accepts a new start just like IDLE so runs can chain without a bubble.
   always_comb begin
      fsm_d   = fsm_q;
      sreg_d  = sreg_q;
      round_d = round_q;
      case (fsm_q)
         IDLE, DONE: begin
            if (bus.start_i) begin
               sreg_d  = loadState;
               round_d = firstRound;
               fsm_d   = RUN;
            end else begin
               fsm_d   = IDLE;
            end
         end
         RUN: begin
            sreg_d = asconRound(sreg_q, round_q);
            if (round_q == 4'd11) begin
               fsm_d   = DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_q   <= IDLE;
         sreg_q  <= '0;
         round_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         sreg_q  <= sreg_d;
         round_q <= round_d;
      end
   end

   assign bus.state_o = sreg_q;
   assign bus.round_o = round_q;
   assign bus.busy_o  = (fsm_q == RUN);
   assign bus.done_o  = (fsm_q == DONE);

endmodule

// File: tb/tb_permutation_sequencer.sv
// Scoreboard bench for permutation_sequencer: a table-driven Ascon model predicts each
// result and its completion cycle; a negedge monitor checks every done_o pulse.
module tb_permutation_sequencer;

   typedef struct {
      logic [4:0][63:0] st;
      int               cyc;
   } expT;

   logic clock;
   logic reset;
   int   cyc;
   int   total;
   int   bad;
   expT  expQ[$];

   logic [4:0] sboxTab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   int rotA [5] = '{19, 61, 1, 10, 7};
   int rotB [5] = '{28, 39, 6, 17, 41};

   permutation_sequencer_if bus ();

   permutation_sequencer dut (
      .clock_i (clock),
      .reset_i (reset),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   function automatic int numRounds(input logic [1:0] r);
      case (r)
         2'b01:   return 8;
         2'b10:   return 6;
         default: return 12;
      endcase
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] v, input int k);
      return (v >> k) | (v << (64 - k));
   endfunction

   // Reference permutation: S-box applied column by column through the lookup table.
   function automatic logic [4:0][63:0] modelPerm(input logic [4:0][63:0] s, input int n);
      logic [4:0][63:0] x;
      logic [4:0][63:0] y;
      logic [4:0]       col;
      logic [4:0]       o;
      x = s;
      for (int r = 12 - n; r < 12; r++) begin
         x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
         for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o   = sboxTab[col];
            for (int w = 0; w < 5; w++) y[w][b] = o[4 - w];
         end
         for (int w = 0; w < 5; w++) x[w] = y[w] ^ rotr(y[w], rotA[w]) ^ rotr(y[w], rotB[w]);
      end
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [319:0] actual,
                              input logic [319:0] expected);
      total = total + 1;
      if (actual !== expected) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [4:0][63:0] randState();
      logic [4:0][63:0] s;
      for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
      return s;
   endfunction

   // Drive a one-cycle start from a point just after a clock edge; returns after acceptance.
   task automatic applyStimulus(input logic [1:0] r, input logic [4:0][63:0] s,
                                input logic [63:0] d);
      expT e;
      logic [4:0][63:0] loaded;
      loaded = s;
      bus.start_i  = 1'b1;
      bus.rounds_i = r;
      bus.state_i  = s;
`ifdef ASCON_PERM_ABSORB_EN
      bus.data_i   = d;
      loaded[0]    = s[0] ^ d;
`else
      if (d != 64'd0) $display("[TB] note: data word ignored without absorb build");
`endif
      @(posedge clock); #1;
      bus.start_i = 1'b0;
      e.st  = modelPerm(loaded, numRounds(r));
      e.cyc = cyc + numRounds(r);
      expQ.push_back(e);
   endtask

   task automatic watchRounds(input int n);
      for (int j = 0; j < n; j++) begin
         checkOutput("roundStep", 320'(bus.round_o), 320'(12 - n + j));
         checkOutput("busyRun", 320'(bus.busy_o), 320'd1);
         @(posedge clock); #1;
      end
      checkOutput("busyDone", 320'(bus.busy_o), 320'd0);
      checkOutput("roundFinal", 320'(bus.round_o), 320'd11);
      @(posedge clock); #1;
   endtask

   // Monitor: every done_o pulse must match the oldest outstanding prediction.
   always @(negedge clock) begin
      expT e;
      if (!reset && bus.done_o) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 320'd1, 320'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("doneCycle", 320'(cyc), 320'(e.cyc));
            checkOutput("result", bus.state_o, e.st);
         end
      end
   end

   initial begin
      logic [4:0][63:0] sa;
      logic [4:0][63:0] sb;
      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      bus.start_i  = 1'b0;
      bus.rounds_i = 2'b00;
      bus.state_i  = '0;
`ifdef ASCON_PERM_ABSORB_EN
      bus.data_i   = '0;
`endif
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      checkOutput("resetState", bus.state_o, 320'd0);
      checkOutput("resetRound", 320'(bus.round_o), 320'd0);
      checkOutput("resetBusy", 320'(bus.busy_o), 320'd0);
      checkOutput("resetDone", 320'(bus.done_o), 320'd0);

      // Random runs across every rounds_i encoding, with round_o/busy_o tracking.
      for (int k = 0; k < 8; k++) begin
         logic [1:0] r;
         r = 2'(k % 4);
         applyStimulus(r, randState(), 64'd0);
         watchRounds(numRounds(r));
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #0;
      end

      // start_i mid-run is ignored.
      sa = randState();
      applyStimulus(2'b00, sa, 64'd0);
      repeat (5) @(posedge clock);
      #1;
      checkOutput("midRound", 320'(bus.round_o), 320'd5);
      bus.start_i  = 1'b1;
      bus.rounds_i = 2'b10;
      bus.state_i  = randState();
      @(posedge clock); #1;
      bus.start_i  = 1'b0;
      repeat (10) @(posedge clock);
      #1;

      // Start held through DONE chains a second run with no bubble.
      sa = randState();
      sb = randState();
      applyStimulus(2'b00, sa, 64'd0);
      bus.start_i = 1'b1;
      bus.state_i = sb;
      repeat (12) @(posedge clock);
      #1;
      checkOutput("chainDone", 320'(bus.done_o), 320'd1);
      begin
         expT e;
         @(posedge clock); #1;
         bus.start_i = 1'b0;
         e.st  = modelPerm(sb, 12);
         e.cyc = cyc + 12;
         expQ.push_back(e);
      end
      checkOutput("chainBusy", 320'(bus.busy_o), 320'd1);
      repeat (14) @(posedge clock);
      #1;

      // Reset at round 7 discards the run.
      bus.start_i  = 1'b1;
      bus.rounds_i = 2'b00;
      bus.state_i  = randState();
      @(posedge clock); #1;
      bus.start_i  = 1'b0;
      repeat (7) @(posedge clock);
      #1;
      checkOutput("preResetRound", 320'(bus.round_o), 320'd7);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checkOutput("midResetState", bus.state_o, 320'd0);
      checkOutput("midResetRound", 320'(bus.round_o), 320'd0);
      checkOutput("midResetBusy", 320'(bus.busy_o), 320'd0);
      checkOutput("midResetDone", 320'(bus.done_o), 320'd0);
      repeat (2) @(posedge clock);
      #1;
      applyStimulus(2'b01, randState(), 64'd0);
      watchRounds(8);

`ifdef ASCON_PERM_ABSORB_EN
      applyStimulus(2'b00, '0, 64'h8040_0C06_0000_0000);
      watchRounds(12);
`endif

      repeat (20) @(posedge clock);
      #1;
      checkOutput("queueDrained", 320'(expQ.size()), 320'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
